// File: rtl/mmu_task_map.sv
// mmu_task_map: task-based page mapper with auto supervisor switch for the 6809 SBC
module mmu_task_map #(
    parameter int PAGE_BITS = 3,
    parameter int TASK_BITS = 2,
    parameter int PHYS_BITS = 8,
    parameter logic [15:0] MMU_BASE = 16'hFE20
) (
    input  logic                 CLKX4,
    input  logic                 nRESET,
    input  logic                 E,
    input  logic [15:0]          ADDR,
    input  logic                 RnW,
    input  logic                 BA,
    input  logic                 BS,
    input  logic [7:0]           DATA_in,
    output logic [7:0]           DATA_out,
    output logic                 DATA_oe,
    output logic                 MMU_SEL,
    output logic [PHYS_BITS-1:0] PHYS_PAGE,
    output logic [TASK_BITS-1:0] TASK
);
    localparam int IDX_BITS = PAGE_BITS + TASK_BITS;
    localparam int NSLOT = 1 << IDX_BITS;
    localparam int NPAGE = 1 << PAGE_BITS;

    logic [1:0]           ctrl;
    logic [TASK_BITS-1:0] cur_task;
    logic [TASK_BITS-1:0] save;
    logic [IDX_BITS-1:0]  ptr;
    logic [PHYS_BITS-1:0] map [NSLOT];
    logic                 e_q;

    logic [2:0]           off;
    logic [PAGE_BITS-1:0] slot;
    logic                 e_fall;
    logic                 wr_en;
    logic                 rd_inc;
    logic                 vec;

    assign off     = ADDR[2:0];
    assign slot    = ADDR[15 -: PAGE_BITS];
    assign MMU_SEL = ADDR[15:3] == MMU_BASE[15:3];
    assign DATA_oe = E & RnW & MMU_SEL;
    assign TASK    = cur_task;
    assign e_fall  = e_q & ~E;
    assign wr_en   = e_fall & ~RnW & MMU_SEL;
    assign rd_inc  = e_fall & RnW & MMU_SEL & (off == 3'd4);
    assign vec     = e_fall & ~BA & BS;

    // Translate the logical page through the current task's table, or pass it through when disabled
    always_comb begin
        PHYS_PAGE = ctrl[0] ? map[{cur_task, slot}] : PHYS_BITS'(slot);
    end

    // Register read mux; offsets 5..7 read as zero
    always_comb begin
        DATA_out = off == 3'd0 ? 8'(ctrl) :
                   off == 3'd1 ? 8'(cur_task) :
                   off == 3'd2 ? 8'(save) :
                   off == 3'd3 ? 8'(ptr) :
                   off == 3'd4 ? 8'(map[ptr]) : 8'h00;
    end

    // Register writes, PTR auto-increment and vector-fetch task switch, all on the E falling edge
    always_ff @(posedge CLKX4) begin
        if (!nRESET) begin
            ctrl     <= '0;
            cur_task <= '0;
            save     <= '0;
            ptr      <= '0;
            e_q      <= 1'b0;
            for (int i = 0; i < NSLOT; i++) map[i] <= PHYS_BITS'(i % NPAGE);
        end else begin
            e_q <= E;
            if (wr_en && off == 3'd0) ctrl <= DATA_in[1:0];
            if (wr_en && off == 3'd1) cur_task <= DATA_in[TASK_BITS-1:0];
            if (wr_en && off == 3'd3) ptr <= DATA_in[IDX_BITS-1:0];
            if (wr_en && off == 3'd4) map[ptr] <= DATA_in[PHYS_BITS-1:0];
            if ((wr_en && off == 3'd4) || rd_inc) ptr <= ptr + IDX_BITS'(1);
            if (wr_en && off == 3'd5) cur_task <= save;
            if (vec && ctrl[1] && cur_task != '0) begin
                save     <= cur_task;
                cur_task <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mmu_task_map.sv
// tb_mmu_task_map: directed bus-cycle checks of the task mapper
module tb_mmu_task_map;
    logic        CLKX4 = 1'b0;
    logic        nRESET = 1'b0;
    logic        E = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic        RnW = 1'b1;
    logic        BA = 1'b0;
    logic        BS = 1'b0;
    logic [7:0]  DATA_in = 8'h00;
    logic [7:0]  DATA_out;
    logic        DATA_oe;
    logic        MMU_SEL;
    logic [7:0]  PHYS_PAGE;
    logic [1:0]  TASK;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;
    logic       oe;

    mmu_task_map dut (
        .CLKX4(CLKX4), .nRESET(nRESET), .E(E), .ADDR(ADDR), .RnW(RnW),
        .BA(BA), .BS(BS), .DATA_in(DATA_in), .DATA_out(DATA_out),
        .DATA_oe(DATA_oe), .MMU_SEL(MMU_SEL), .PHYS_PAGE(PHYS_PAGE), .TASK(TASK)
    );

    always #5 CLKX4 = ~CLKX4;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU cycle: E high for two CLKX4 periods, then low; the DUT commits on the edge after E falls
    task automatic bus(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                       input logic vf, input logic rst_fall,
                       output logic [7:0] rdata, output logic rdoe);
        @(negedge CLKX4);
        ADDR = a; RnW = rnw; DATA_in = d; BA = 1'b0; BS = vf; E = 1'b1;
        @(negedge CLKX4);
        rdata = DATA_out; rdoe = DATA_oe;
        @(negedge CLKX4);
        E = 1'b0;
        if (rst_fall) nRESET = 1'b0;
        @(negedge CLKX4);
        nRESET = 1'b1; BS = 1'b0; RnW = 1'b1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        logic [7:0] x; logic y;
        bus(a, 1'b0, d, 1'b0, 1'b0, x, y);
    endtask

    task automatic rdreg(input logic [15:0] a, output logic [7:0] d);
        logic y;
        bus(a, 1'b1, 8'h00, 1'b0, 1'b0, d, y);
    endtask

    task automatic vfetch(input logic [15:0] a);
        logic [7:0] x; logic y;
        bus(a, 1'b1, 8'h00, 1'b1, 1'b0, x, y);
    endtask

    task automatic setaddr(input logic [15:0] a);
        @(negedge CLKX4);
        ADDR = a;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLKX4);
        nRESET = 1'b0;
        repeat (2) @(negedge CLKX4);
        nRESET = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge CLKX4);
        @(negedge CLKX4);
        nRESET = 1'b1;

        setaddr(16'hA000);
        chk("rst_phys", 16'(PHYS_PAGE), 16'h05);
        chk("rst_task", 16'(TASK), 16'h0);
        chk("rst_oe", 16'(DATA_oe), 16'h0);
        bus(16'hFE20, 1'b1, 8'h00, 1'b0, 1'b0, rd, oe);
        chk("rst_ctrl", 16'(rd), 16'h00);
        chk("rd_oe", 16'(oe), 16'h1);
        rdreg(16'hFE22, rd);
        chk("rst_save", 16'(rd), 16'h00);
        setaddr(16'hFE27);
        chk("sel_top", 16'(MMU_SEL), 16'h1);
        setaddr(16'hFE28);
        chk("sel_above", 16'(MMU_SEL), 16'h0);
        setaddr(16'hFE1F);
        chk("sel_below", 16'(MMU_SEL), 16'h0);

        wr(16'hFE23, 8'h1F);
        wr(16'hFE24, 8'h3C);
        wr(16'hFE24, 8'h41);
        rdreg(16'hFE23, rd);
        chk("ptr_wrap", 16'(rd), 16'h01);
        wr(16'hFE23, 8'h1F);
        rdreg(16'hFE24, rd);
        chk("map_3_7", 16'(rd), 16'h3C);
        rdreg(16'hFE24, rd);
        chk("map_0_0", 16'(rd), 16'h41);
        rdreg(16'hFE23, rd);
        chk("ptr_rd_inc", 16'(rd), 16'h01);
        rdreg(16'hFE26, rd);
        chk("rd_off6", 16'(rd), 16'h00);

        wr(16'hFE23, 8'h17);
        wr(16'hFE24, 8'h9A);
        wr(16'hFE21, 8'h02);
        wr(16'hFE20, 8'h01);
        setaddr(16'hE123);
        chk("xlat_2_7", 16'(PHYS_PAGE), 16'h9A);
        wr(16'hFE21, 8'hFF);
        chk("task_mask", 16'(TASK), 16'h3);
        setaddr(16'hE000);
        chk("xlat_3_7", 16'(PHYS_PAGE), 16'h3C);
        wr(16'hFE21, 8'h02);
        wr(16'hFE20, 8'h00);
        setaddr(16'hE123);
        chk("xlat_off", 16'(PHYS_PAGE), 16'h07);

        wr(16'hFE20, 8'h03);
        rdreg(16'hFE20, rd);
        chk("ctrl_rb", 16'(rd), 16'h03);
        vfetch(16'hFFF8);
        chk("auto_task1", 16'(TASK), 16'h0);
        rdreg(16'hFE22, rd);
        chk("auto_save1", 16'(rd), 16'h02);
        vfetch(16'hFFF9);
        chk("auto_task2", 16'(TASK), 16'h0);
        rdreg(16'hFE22, rd);
        chk("auto_save2", 16'(rd), 16'h02);
        wr(16'hFE25, 8'h00);
        chk("restore", 16'(TASK), 16'h2);
        rdreg(16'hFE21, rd);
        chk("restore_rd", 16'(rd), 16'h02);

        do_reset();
        wr(16'hFE20, 8'h01);
        wr(16'hFE21, 8'h03);
        vfetch(16'hFFF8);
        chk("noauto_task", 16'(TASK), 16'h3);
        rdreg(16'hFE22, rd);
        chk("noauto_save", 16'(rd), 16'h00);

        wr(16'hFE23, 8'h0A);
        bus(16'hFE24, 1'b0, 8'h77, 1'b0, 1'b1, rd, oe);
        rdreg(16'hFE23, rd);
        chk("midrst_ptr", 16'(rd), 16'h00);
        rdreg(16'hFE20, rd);
        chk("midrst_ctrl", 16'(rd), 16'h00);
        wr(16'hFE23, 8'h0A);
        rdreg(16'hFE24, rd);
        chk("midrst_map", 16'(rd), 16'h02);
        rdreg(16'hFE23, rd);
        chk("midrst_ptr2", 16'(rd), 16'h0B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
